keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 147 ++++++++++++++
 tb/tb_keypad_scanner.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: steps one-cold column drive, debounces press/release on scan ticks.
// Latency: 2-cycle row synchronizer, then DEBOUNCE_SCANS ticks to accept; key_valid the cycle after the accepting tick.
// Backpressure: none; key_valid is a single-cycle pulse with no ready handshake.
module keypad_scanner #(
    parameter int CLK_FREQ       = 12000000,
    parameter int SCAN_HZ        = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int TICK_DIV = CLK_FREQ / SCAN_HZ;
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t        state;
    logic [3:0]    rs_meta;
    logic [3:0]    rs;
    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [1:0]    col_idx;
    logic [1:0]    lrow;
    logic [1:0]    lcol;
    logic [3:0]    dcnt;
    logic [1:0]    low_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_meta <= 4'hF;
            rs      <= 4'hF;
        end else begin
            rs_meta <= rows;
            rs      <= rs_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Lowest-index pressed row wins when several rows are low together.
    always_comb begin
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rs[i]) low_row = 2'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            cols      <= 4'b1110;
            col_idx   <= 2'd0;
            lrow      <= 2'd0;
            lcol      <= 2'd0;
            dcnt      <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (rs == 4'hF) begin
                            cols    <= {cols[2:0], cols[3]};
                            col_idx <= col_idx + 2'd1;
                        end else begin
                            lrow <= low_row;
                            lcol <= col_idx;
                            dcnt <= 4'd1;
                            if (DEBOUNCE_SCANS == 1) begin
                                state     <= HELD;
                                key_code  <= {low_row, col_idx};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (!rs[lrow]) begin
                            dcnt <= dcnt + 4'd1;
                            if (dcnt + 4'd1 == DB_N) begin
                                state     <= HELD;
                                key_code  <= {lrow, lcol};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end
                        end else begin
                            state   <= SCAN;
                            cols    <= {cols[2:0], cols[3]};
                            col_idx <= col_idx + 2'd1;
                        end
                    end
                    HELD: begin
                        // Only the latched row matters here; other keys are ignored.
                        if (rs[lrow]) begin
                            dcnt <= 4'd1;
                            if (DEBOUNCE_SCANS == 1) begin
                                state    <= SCAN;
                                key_held <= 1'b0;
                                cols     <= {cols[2:0], cols[3]};
                                col_idx  <= col_idx + 2'd1;
                            end else begin
                                state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (rs[lrow]) begin
                            dcnt <= dcnt + 4'd1;
                            if (dcnt + 4'd1 == DB_N) begin
                                state    <= SCAN;
                                key_held <= 1'b0;
                                cols     <= {cols[2:0], cols[3]};
                                col_idx  <= col_idx + 2'd1;
                            end
                        end else begin
                            state <= HELD;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a modelled 4x4 key matrix driven from a table of press masks.
module tb_keypad_scanner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] press;

    int n_checks;
    int n_fail;
    int oc_bad;

    keypad_scanner #(
        .CLK_FREQ      (1000),
        .SCAN_HZ       (100),
        .DEBOUNCE_SCANS(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rows     (rows),
        .cols     (cols),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key r*4+c shorts row r to column c while that column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (press[r*4+c] && !cols[c]) rows[r] = 1'b0;
            end
        end
    end

    typedef struct {
        logic [15:0] press;
        int          ticks;
        logic [3:0]  exp_cols;
        logic [3:0]  exp_code;
        logic        exp_held;
        int          exp_valid;
    } vec_t;

    vec_t vt[20];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs n scan periods (10 clocks each), counting key_valid pulses and one-cold violations.
    task automatic run_ticks(input int n, output int nv);
        nv = 0;
        for (int k = 0; k < n * 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (key_valid) nv++;
            if (!(cols == 4'b1110 || cols == 4'b1101 || cols == 4'b1011 || cols == 4'b0111)) oc_bad++;
        end
    endtask

    initial begin
        int nv;
        n_checks = 0;
        n_fail   = 0;
        oc_bad   = 0;
        press    = 16'h0000;
        rst_n    = 1'b0;

        //            press     ticks cols     code  held valid
        vt[0]  = '{16'h0000, 0, 4'b1110, 4'd0, 1'b0, 0};
        vt[1]  = '{16'h0000, 1, 4'b1101, 4'd0, 1'b0, 0};
        vt[2]  = '{16'h0000, 2, 4'b0111, 4'd0, 1'b0, 0};
        vt[3]  = '{16'h0000, 1, 4'b1110, 4'd0, 1'b0, 0};
        vt[4]  = '{16'h0200, 1, 4'b1101, 4'd0, 1'b0, 0};
        vt[5]  = '{16'h0200, 3, 4'b1101, 4'd0, 1'b0, 0};
        vt[6]  = '{16'h0200, 1, 4'b1101, 4'd9, 1'b1, 1};
        vt[7]  = '{16'h0200, 5, 4'b1101, 4'd9, 1'b1, 0};
        vt[8]  = '{16'h0000, 2, 4'b1101, 4'd9, 1'b1, 0};
        vt[9]  = '{16'h0200, 1, 4'b1101, 4'd9, 1'b1, 0};
        vt[10] = '{16'h0000, 3, 4'b1101, 4'd9, 1'b1, 0};
        vt[11] = '{16'h0000, 1, 4'b1011, 4'd9, 1'b0, 0};
        vt[12] = '{16'h0004, 2, 4'b1011, 4'd9, 1'b0, 0};
        vt[13] = '{16'h0000, 1, 4'b0111, 4'd9, 1'b0, 0};
        vt[14] = '{16'h0000, 1, 4'b1110, 4'd9, 1'b0, 0};
        vt[15] = '{16'h1010, 4, 4'b1110, 4'd4, 1'b1, 1};
        vt[16] = '{16'h1011, 2, 4'b1110, 4'd4, 1'b1, 0};
        vt[17] = '{16'h1001, 4, 4'b1101, 4'd4, 1'b0, 0};
        vt[18] = '{16'h0000, 1, 4'b1011, 4'd4, 1'b0, 0};
        vt[19] = '{16'h0000, 2, 4'b1110, 4'd4, 1'b0, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset key_valid", int'(key_valid), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            press = vt[i].press;
            run_ticks(vt[i].ticks, nv);
            check($sformatf("v%0d cols", i), int'(cols), int'(vt[i].exp_cols));
            check($sformatf("v%0d key_code", i), int'(key_code), int'(vt[i].exp_code));
            check($sformatf("v%0d key_held", i), int'(key_held), int'(vt[i].exp_held));
            check($sformatf("v%0d valid pulses", i), nv, vt[i].exp_valid);
        end

        // Reset while debouncing key 12, then expect a fresh single acceptance.
        press = 16'h1000;
        run_ticks(2, nv);
        check("pre-reset valid pulses", nv, 0);
        check("pre-reset cols frozen", int'(cols), int'(4'b1110));
        rst_n = 1'b0;
        #1;
        check("async reset cols", int'(cols), int'(4'b1110));
        check("async reset key_code", int'(key_code), 0);
        check("async reset key_held", int'(key_held), 0);
        check("async reset key_valid", int'(key_valid), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_ticks(3, nv);
        check("post-reset debounce pulses", nv, 0);
        check("post-reset debounce held", int'(key_held), 0);
        run_ticks(1, nv);
        check("post-reset accept pulses", nv, 1);
        check("post-reset key_code", int'(key_code), 12);
        check("post-reset key_held", int'(key_held), 1);
        run_ticks(3, nv);
        check("post-reset no repeat", nv, 0);

        check("one-cold violations", oc_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
